mat_host_dma: RTL

- Host-side bulk mover for the matrix core's data memory. It is the other end of the data-memory row interface that MatControl drives.
- Load: accepts a stream of WIDTH-element rows from the host and writes them into MatDataMem.
- Store: reads rows back out of MatDataMem and streams them to the host.
- Replaces bench-side file preload/dump. Owns the data-memory port only while busy; external muxing to MatControl is keyed on busy.

---
 rtl/mat_host_dma_if.sv | 58 +++++
 rtl/mat_host_dma.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mat_host_dma_if.sv
// Shared write-op type plus the command, row-stream and data-memory port bundle
// between the host-side bulk mover and its surroundings.
package mat_host_dma_pkg;
  typedef enum logic {
    MEM_WR_NOP = 1'b0,
    MEM_WR_ROW = 1'b1
  } mat_data_mem_write_op_t;
endpackage

interface mat_host_dma_if #(
  parameter int WIDTH              = 16,
  parameter int DATA_MEM_ADDR_SIZE = 32,
  parameter int COUNT_SIZE         = 16
);
  logic                                      cmd_valid;
  logic                                      cmd_ready;
  logic                                      cmd_store;
  logic [DATA_MEM_ADDR_SIZE-1:0]             cmd_addr;
  logic [COUNT_SIZE-1:0]                     cmd_count;

  logic                                      in_valid;
  logic                                      in_ready;
  logic [WIDTH-1:0][31:0]                    in_data;

  logic                                      out_valid;
  logic                                      out_ready;
  logic [WIDTH-1:0][31:0]                    out_data;

  logic [DATA_MEM_ADDR_SIZE-1:0]             data_mem_read_addr;
  logic [WIDTH-1:0][31:0]                    data_mem_data_out;
  mat_host_dma_pkg::mat_data_mem_write_op_t  data_mem_write_op;
  logic [DATA_MEM_ADDR_SIZE-1:0]             data_mem_write_addr;
  logic [WIDTH-1:0][31:0]                    data_mem_data_in;

  modport slave (
    input  cmd_valid, cmd_store, cmd_addr, cmd_count,
    output cmd_ready,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data,
    input  out_ready,
    output data_mem_read_addr,
    input  data_mem_data_out,
    output data_mem_write_op, data_mem_write_addr, data_mem_data_in
  );

  modport master (
    output cmd_valid, cmd_store, cmd_addr, cmd_count,
    input  cmd_ready,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data,
    output out_ready,
    input  data_mem_read_addr,
    output data_mem_data_out,
    input  data_mem_write_op, data_mem_write_addr, data_mem_data_in
  );
endinterface

// File: rtl/mat_host_dma.sv
// Host-side row mover for MatDataMem: LOAD streams host rows into memory, STORE streams rows out.
// Optional MAT_HOST_DMA_CHECKSUM_EN adds an XOR checksum over every transferred row.
module mat_host_dma
  import mat_host_dma_pkg::*;
#(
  parameter int WIDTH              = 16,
  parameter int DATA_MEM_SIZE      = 1024,
  parameter int DATA_MEM_ADDR_SIZE = 32,
  parameter int COUNT_SIZE         = 16
) (
  input  logic        clock,
  input  logic        reset,
  mat_host_dma_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef MAT_HOST_DMA_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam int AW = DATA_MEM_ADDR_SIZE;
  localparam int CW = COUNT_SIZE;
  localparam logic [AW:0] MEM_ROWS = (AW+1)'(DATA_MEM_SIZE);

  typedef logic [WIDTH-1:0][31:0] row_t;
  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  state_t        state;
  logic [AW-1:0] cur_addr;
  logic [CW-1:0] remaining;
  logic          cmd_ready_r;
  logic          in_ready_r;
  logic          out_valid_r;

  logic          cmd_fire;
  logic          in_fire;
  logic          out_fire;
  logic [AW:0]   cmd_end;

`ifdef MAT_HOST_DMA_CHECKSUM_EN
  function automatic logic [31:0] row_fold(input row_t row);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < WIDTH; i++) acc ^= row[i];
    return acc;
  endfunction
`endif

  assign cmd_fire = bus.cmd_valid && cmd_ready_r;
  assign in_fire  = bus.in_valid && in_ready_r;
  assign out_fire = out_valid_r && bus.out_ready;
  // One extra bit so addr + count cannot wrap past the top of the address space.
  assign cmd_end  = {1'b0, bus.cmd_addr} + (AW+1)'(bus.cmd_count);

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;

  // Write path is combinational so the memory commits on the handshake edge itself;
  // gating on the registered ready makes an async reset kill any in-flight write at once.
  assign bus.data_mem_write_op   = in_fire ? MEM_WR_ROW : MEM_WR_NOP;
  assign bus.data_mem_write_addr = in_fire ? cur_addr : '0;
  assign bus.data_mem_data_in    = in_fire ? bus.in_data : '0;

  assign bus.data_mem_read_addr  = out_valid_r ? cur_addr : '0;
  assign bus.out_data            = out_valid_r ? bus.data_mem_data_out : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      cmd_ready_r <= 1'b1;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef MAT_HOST_DMA_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            cur_addr  <= bus.cmd_addr;
            remaining <= bus.cmd_count;
`ifdef MAT_HOST_DMA_CHECKSUM_EN
            checksum  <= '0;
`endif
            if (cmd_end > MEM_ROWS) begin
              err <= 1'b1;
            end else if (bus.cmd_count == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              busy        <= 1'b1;
              cmd_ready_r <= 1'b0;
            end else begin
              state       <= bus.cmd_store ? STORE : LOAD;
              busy        <= 1'b1;
              cmd_ready_r <= 1'b0;
              in_ready_r  <= !bus.cmd_store;
              out_valid_r <= bus.cmd_store;
            end
          end
        end

        LOAD: begin
          if (in_fire) begin
            remaining <= remaining - CW'(1);
`ifdef MAT_HOST_DMA_CHECKSUM_EN
            checksum  <= checksum ^ row_fold(bus.in_data);
`endif
            // The last row leaves cur_addr on it, so it never steps past the memory.
            if (remaining == CW'(1)) begin
              state      <= DONE;
              in_ready_r <= 1'b0;
              done       <= 1'b1;
            end else begin
              cur_addr <= cur_addr + AW'(1);
            end
          end
        end

        STORE: begin
          if (out_fire) begin
            remaining <= remaining - CW'(1);
`ifdef MAT_HOST_DMA_CHECKSUM_EN
            checksum  <= checksum ^ row_fold(bus.data_mem_data_out);
`endif
            if (remaining == CW'(1)) begin
              state       <= DONE;
              out_valid_r <= 1'b0;
              done        <= 1'b1;
            end else begin
              cur_addr <= cur_addr + AW'(1);
            end
          end
        end

        DONE: begin
          state       <= IDLE;
          busy        <= 1'b0;
          cmd_ready_r <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
